// File: rtl/mux_arb_n.sv
// Registered N-channel arbitrating multiplexer with valid/ready handshakes and a one-entry output register.
// Define MUX_ARB_RR_EN for round-robin arbitration; left undefined, the lowest-index valid channel wins.
//
// state | meaning
// EMPTY | output register holds no word (out_valid=0)
// FULL  | output register holds a word awaiting out_ready (out_valid=1)
module mux_arb_n #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            state;
   logic [SEL_W-1:0]  ptr;
   logic              can_load;
   logic              win_found;
   logic [SEL_W-1:0]  win_idx;
   logic [SEL_W-1:0]  cand;
   logic [WIDTH-1:0]  win_data;
   logic              load;
   logic [WIDTH-1:0]  ch_data [CHANNELS];

   for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
      assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
   end

`ifndef MUX_ARB_RR_EN
   // Fixed priority: scanning always starts at channel 0.
   assign ptr = '0;
`endif

   assign out_valid = (state == FULL);
   assign can_load  = ~out_valid | out_ready;

   // Scan from ptr upwards, wrapping naturally since CHANNELS is a power of two.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cand = ptr + SEL_W'(i);
         if (!win_found && in_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign win_data = ch_data[win_idx];
   assign load     = win_found & can_load;

   always_comb begin
      in_ready = '0;
      if (load && !rst) begin
         in_ready[win_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         out_data <= '0;
         out_sel  <= '0;
`ifdef MUX_ARB_RR_EN
         ptr      <= '0;
`endif
      end else begin
         case (state)
            EMPTY: begin
               if (load) begin
                  state <= FULL;
               end
            end
            FULL: begin
               if (out_ready && !win_found) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
         // A load in FULL replaces the drained word on the same edge.
         if (load) begin
            out_data <= win_data;
            out_sel  <= win_idx;
`ifdef MUX_ARB_RR_EN
            ptr      <= win_idx + SEL_W'(1);
`endif
         end
      end
   end

endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Registered N-channel arbitrating multiplexer: selects one of CHANNELS WIDTH-bit input streams per cycle using valid/ready handshakes and holds the winner in a one-entry output register until the consumer accepts it. It is the sequential successor to the combinational `_MUX_*to1_n` family. It sits wherever several datapath producers share one consumer: register-file write-back, memory request port, or bus master arbitration. Input data uses the same packed-bus convention as the existing mux library, with channel k at `in_data[(k+1)*WIDTH-1 : k*WIDTH]`.

## Interface
- WIDTH, 8: data bits per channel; legal range 1..64.
- CHANNELS, 4: number of input channels; must be 2, 4, 8 or 16.
- SEL_W (localparam): log2(CHANNELS).
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  CHANNELS  per-channel request; bit k belongs to channel k.
- in_data  input  CHANNELS*WIDTH  packed channel data.
- in_ready  output  CHANNELS  one-hot-or-zero grant; channel k transfers when in_valid[k] & in_ready[k].
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the output word this cycle.
- out_data  output  WIDTH  registered winning data.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.

## Operation
- State: output register (out_valid, out_data, out_sel) plus priority pointer ptr[SEL_W-1:0]. Two effective states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=0.
- can_load = ~out_valid | out_ready. This is combinational, so in_ready depends combinationally on out_ready and in_valid.
- Arbitration (round-robin): scan channels ptr, ptr+1, … modulo CHANNELS. The first k with in_valid[k]=1 wins. Drive in_ready[k]=can_load; all other in_ready bits are 0.
- Load: if can_load and any in_valid, then on the next edge:
  - out_data takes the winner's data, out_sel takes k, out_valid goes to 1.
  - ptr takes (k+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
- Drain: if out_valid & out_ready and no in_valid, then out_valid goes to 0. out_data and out_sel hold their last values.
- Simultaneous drain and load in the FULL state: the new word replaces the old one in the same edge with no bubble, giving full throughput of one word per cycle.
- FULL & ~out_ready: all in_ready are 0. out_data and out_sel are held stable, and ptr does not move.
- No requests: ptr does not move. A grant is never issued to a channel whose in_valid=0.
- in_valid may deassert without a transfer; the block does not require it to be sticky.
- rst asserted mid-transfer: the held word is discarded and all state returns to reset values on that edge. in_ready is 0 while rst=1.

## Timing
- Latency: 1 cycle from an accepted input (in_valid&in_ready at edge n) to out_valid=1 with that data after edge n.
- Throughput: 1 word per cycle when out_ready is held at 1.
- Fairness: with all channels requesting and out_ready=1, each channel is granted exactly once every CHANNELS cycles.
- Critical path: ptr to rotate, priority pick, and data mux to the output register. Combinational paths from out_ready to in_ready and from in_valid to in_ready are allowed. There is no combinational path from any input to out_*.

## Configuration
- MUX_ARB_RR_EN defined: round-robin arbitration as described above.
- MUX_ARB_RR_EN not defined: fixed priority, where the lowest-index valid channel always wins.
  - ptr is not implemented and is treated as constant 0.
  - All other handshake and timing behaviour is identical.

## Test plan
- Reset: assert rst for 2 cycles with all in_valid=1. Required: in_ready=0, out_valid=0, out_data=0, out_sel=0; after release, the first grant goes to ch0.
- Round-robin: CHANNELS=4, WIDTH=8, all valid with data 0xA0..0xA3, out_ready=1. Required: out_sel sequence 0,1,2,3,0,… and out_data 0xA0,0xA1,0xA2,0xA3,0xA0, one per cycle. Without MUX_ARB_RR_EN: out_sel stays 0 on every cycle.
- Backpressure: load 0x55 from ch2, then hold out_ready=0 for 5 cycles while ch1 and ch3 are valid. Required: in_ready=0, out_data=0x55 and out_sel=2 are stable. On release, ch3 wins in RR mode and ch1 in fixed mode.
- Wrap and sparse requests: after a grant to ch3, only ch0 and ch2 are valid. Required: ch0 wins, then ch2. An idle cycle leaves ptr unchanged.
- Simultaneous drain/load and no-request drain: in FULL with out_ready=1 and ch1 valid, the new word appears with no gap. With no valid inputs, out_valid drops next cycle.
- Mid-operation reset: rst=1 while FULL with out_ready=0. Required: out_valid=0 on the next edge, and the held word is never presented.
